// File: rtl/pc_target_unit.sv
// Program counter with a runtime-writable branch-target table, halt state and
// a saturating count of taken branches; pc drives the instruction ROM address.
module pc_target_unit #(
    parameter int unsigned D        = 12,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned A        = $clog2(DEPTH),
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [A-1:0]     branch_sel,
    input  logic             halt_req,
    input  logic             wr_en,
    input  logic [A-1:0]     wr_addr,
    input  logic [D-1:0]     wr_data,
    input  logic             wr_abs,
    output logic [D-1:0]     pc,
    output logic             done,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [D-1:0] RESET_VAL = D'(RESET_PC);

    state_t         state;
    state_t         state_next;
    logic [D-1:0]   pc_next;
    logic           cnt_inc;

    logic [D-1:0]   tbl_target [DEPTH];
    logic           tbl_abs    [DEPTH];

    logic [D-1:0]   sel_target;
    logic           sel_abs;

    // Table read sees pre-write contents, so a same-cycle write is not bypassed.
    assign sel_target = tbl_target[branch_sel];
    assign sel_abs    = tbl_abs[branch_sel];

    always_comb begin
        state_next = state;
        pc_next    = pc;
        cnt_inc    = 1'b0;
        case (state)
            RUN: begin
                if (halt_req) begin
                    state_next = HALTED;
                end else if (stall) begin
                    pc_next = pc;
                end else if (branch_taken) begin
                    cnt_inc = 1'b1;
                    pc_next = sel_abs ? sel_target : pc + sel_target;
                end else begin
                    pc_next = pc + D'(1);
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            pc        <= RESET_VAL;
            taken_cnt <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (cnt_inc && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl_target[i] <= '0;
                tbl_abs[i]    <= 1'b0;
            end
        end else if (wr_en) begin
            tbl_target[wr_addr] <= wr_data;
            tbl_abs[wr_addr]    <= wr_abs;
        end
    end

    assign done = (state == HALTED);

endmodule

// File: tb/tb_pc_target_unit.sv
// Directed-vector bench for pc_target_unit; a second instance with a 3-bit
// counter shares the stimulus to exercise counter saturation.
module tb_pc_target_unit;

    localparam int unsigned D     = 12;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned A     = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          branch_taken;
    logic [A-1:0]  branch_sel;
    logic          halt_req;
    logic          wr_en;
    logic [A-1:0]  wr_addr;
    logic [D-1:0]  wr_data;
    logic          wr_abs;
    logic [D-1:0]  pc;
    logic          done;
    logic [15:0]   taken_cnt;
    logic [D-1:0]  pc_s;
    logic          done_s;
    logic [2:0]    taken_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_target_unit #(.D(D), .DEPTH(DEPTH), .RESET_PC(0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_sel(branch_sel), .halt_req(halt_req), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_abs(wr_abs),
        .pc(pc), .done(done), .taken_cnt(taken_cnt)
    );

    pc_target_unit #(.D(D), .DEPTH(DEPTH), .RESET_PC(0), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_sel(branch_sel), .halt_req(halt_req), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_abs(wr_abs),
        .pc(pc_s), .done(done_s), .taken_cnt(taken_cnt_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_sel = '0;
        halt_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_abs = 1'b0;
    endtask

    // Inputs set before the call are sampled at the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic write_entry(input int unsigned addr, input int unsigned data, input logic abs);
        wr_en = 1'b1; wr_addr = A'(addr); wr_data = D'(data); wr_abs = abs;
        step();
        wr_en = 1'b0;
    endtask

    task automatic branch(input int unsigned sel);
        branch_taken = 1'b1; branch_sel = A'(sel);
        step();
        branch_taken = 1'b0;
    endtask

    task automatic run_to(input int unsigned target);
        for (int i = 0; i < 5000 && pc != D'(target); i++) step();
        check("run_to", 32'(pc), target);
    endtask

    initial begin
        idle();
        step();

        // Reset and sequencing
        do_reset();
        check("rst_pc", 32'(pc), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cnt", 32'(taken_cnt), 0);
        step(); check("seq_pc1", 32'(pc), 1);
        step(); check("seq_pc2", 32'(pc), 2);
        step(); check("seq_pc3", 32'(pc), 3);
        check("seq_done", 32'(done), 0);
        branch(3);
        check("unprog_pc", 32'(pc), 3);
        check("unprog_cnt", 32'(taken_cnt), 1);

        // Relative and absolute targets
        do_reset();
        write_entry(1, 12'hFFB, 1'b0);
        write_entry(5, 200, 1'b1);
        run_to(10);
        branch(1);
        check("rel_neg_pc", 32'(pc), 5);
        branch(5);
        check("abs_pc", 32'(pc), 200);
        check("relabs_cnt", 32'(taken_cnt), 2);

        // Wrap-around in both directions
        write_entry(2, 20, 1'b0);
        write_entry(6, 12'hFFF, 1'b1);
        run_to(4090);
        branch(2);
        check("wrap_rel_pc", 32'(pc), 14);
        branch(6);
        check("abs_top_pc", 32'(pc), 4095);
        step();
        check("wrap_inc_pc", 32'(pc), 0);

        // Read/write collision and stall
        do_reset();
        write_entry(0, 5, 1'b0);
        run_to(8);
        branch_taken = 1'b1; branch_sel = 0;
        wr_en = 1'b1; wr_addr = 0; wr_data = 100; wr_abs = 1'b1;
        step();
        idle();
        check("collide_old_pc", 32'(pc), 13);
        branch(0);
        check("collide_new_pc", 32'(pc), 100);
        check("collide_cnt", 32'(taken_cnt), 2);
        stall = 1'b1; branch_taken = 1'b1; branch_sel = 0;
        step();
        idle();
        check("stall_pc", 32'(pc), 100);
        check("stall_cnt", 32'(taken_cnt), 2);
        step();
        check("post_stall_pc", 32'(pc), 101);

        // Halt
        do_reset();
        run_to(50);
        check("pre_halt_done", 32'(done), 0);
        halt_req = 1'b1;
        step();
        idle();
        check("halt_pc", 32'(pc), 50);
        check("halt_done", 32'(done), 1);
        branch(5);
        check("halt_br_pc", 32'(pc), 50);
        check("halt_br_cnt", 32'(taken_cnt), 0);
        stall = 1'b1; step(); idle();
        step();
        check("halt_idle_pc", 32'(pc), 50);
        write_entry(4, 7, 1'b1);
        check("halt_wr_done", 32'(done), 1);
        do_reset();
        check("unhalt_pc", 32'(pc), 0);
        check("unhalt_done", 32'(done), 0);
        branch(4);
        check("reset_tbl_pc", 32'(pc), 0);

        // Counter saturation on the 3-bit instance
        do_reset();
        check("sat_rst_cnt", 32'(taken_cnt_s), 0);
        for (int i = 1; i <= 9; i++) begin
            branch(0);
            check("sat_cnt", 32'(taken_cnt_s), (i > 7) ? 7 : i);
        end
        check("wide_cnt", 32'(taken_cnt), 9);
        check("sat_pc_match", 32'(pc_s), 32'(pc));
        check("sat_done", 32'(done_s), 0);
        do_reset();
        check("sat_reset_cnt", 32'(taken_cnt_s), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
